// File: rtl/race_pkg.sv
// race_pkg: shared defaults, state encoding and width helper for the race sequencer.
package race_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int PROD_W_DEF = 64;

    typedef enum logic [2:0] {LOAD, ISSUE, WAIT, ACCUM, DONE} state_e;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/race_buffer.sv
// race_buffer: register file holding buffered {time, distance} pairs, sync write, comb read.
module race_buffer #(
    parameter int DEPTH = 8,
    parameter int W     = 64,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/race_sequencer.sv
// race_sequencer: buffers a burst of races, feeds them one at a time to the solver
// and multiplies the per-race win counts into a single product.
module race_sequencer
    import race_pkg::*;
#(
    parameter int MAX_RACES = 8,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int PROD_W    = PROD_W_DEF,
    parameter int TIMEOUT   = 65535
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_tim,
    input  logic [DATA_W-1:0]            in_dist,
    input  logic                         in_last,
    output logic [DATA_W-1:0]            sol_tim,
    output logic [DATA_W-1:0]            sol_dist,
    output logic                         sol_start,
    input  logic [DATA_W-1:0]            sol_res,
    input  logic                         sol_fin,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PROD_W-1:0]            out_product,
    output logic [cnt_w(MAX_RACES)-1:0]  out_count,
    output logic                         out_ovf,
    output logic                         out_timeout
);
    localparam int CW = cnt_w(MAX_RACES);
    localparam int AW = MAX_RACES > 1 ? $clog2(MAX_RACES) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int FW = PROD_W + DATA_W;

    state_e              state_q, state_d;
    logic [CW-1:0]       count_q, count_d, idx_q, idx_d;
    logic [PROD_W-1:0]   product_q, product_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [DATA_W-1:0]   res_q, res_d, tim_q, tim_d, dist_q, dist_d;
    logic                start_q, start_d, ovf_q, ovf_d, tmo_q, tmo_d, fin_q;
    logic [2*DATA_W-1:0] rdata;
    logic [FW-1:0]       full;
    logic                beat, finish;

    race_buffer #(.DEPTH(MAX_RACES), .W(2 * DATA_W), .AW(AW)) u_buf (
        .clk     (clk),
        .we_i    (beat),
        .waddr_i (count_q[AW-1:0]),
        .wdata_i ({in_tim, in_dist}),
        .raddr_i (idx_q[AW-1:0]),
        .rdata_o (rdata)
    );

    assign beat   = in_valid && in_ready;
    // a level still high from the previous race must not count as a finish
    assign finish = sol_fin && !fin_q;
    assign full   = {{DATA_W{1'b0}}, product_q} * {{PROD_W{1'b0}}, res_q};

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        product_d = product_q;
        timer_d   = timer_q;
        res_d     = res_q;
        tim_d     = tim_q;
        dist_d    = dist_q;
        start_d   = 1'b0;
        ovf_d     = ovf_q;
        tmo_d     = tmo_q;
        case (state_q)
            LOAD: if (beat) begin
                count_d = count_q + CW'(1);
                if (in_last || count_d == CW'(MAX_RACES)) begin
                    state_d = ISSUE;
                    idx_d   = '0;
                end
            end
            ISSUE: begin
                {tim_d, dist_d} = rdata;
                start_d = 1'b1;
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: if (finish) begin
                res_d   = sol_res;
                state_d = ACCUM;
            end else if (timer_q == TW'(TIMEOUT)) begin
                tmo_d   = 1'b1;
                state_d = DONE;
            end else begin
                timer_d = timer_q + TW'(1);
            end
            ACCUM: begin
                product_d = full[PROD_W-1:0];
                ovf_d     = ovf_q | (|full[FW-1:PROD_W]);
                idx_d     = idx_q + CW'(1);
                state_d   = (idx_d == count_q) ? DONE : ISSUE;
            end
            DONE: if (out_ready) begin
                state_d   = LOAD;
                count_d   = '0;
                idx_d     = '0;
                product_d = PROD_W'(1);
                ovf_d     = 1'b0;
                tmo_d     = 1'b0;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= LOAD;
            count_q   <= '0;
            idx_q     <= '0;
            product_q <= PROD_W'(1);
            timer_q   <= '0;
            res_q     <= '0;
            tim_q     <= '0;
            dist_q    <= '0;
            start_q   <= 1'b0;
            ovf_q     <= 1'b0;
            tmo_q     <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            product_q <= product_d;
            timer_q   <= timer_d;
            res_q     <= res_d;
            tim_q     <= tim_d;
            dist_q    <= dist_d;
            start_q   <= start_d;
            ovf_q     <= ovf_d;
            tmo_q     <= tmo_d;
            fin_q     <= sol_fin;
        end
    end

    assign in_ready    = state_q == LOAD;
    assign sol_tim     = tim_q;
    assign sol_dist    = dist_q;
    assign sol_start   = start_q;
    assign out_valid   = state_q == DONE;
    assign out_product = product_q;
    assign out_count   = idx_q;
    assign out_ovf     = ovf_q;
    assign out_timeout = tmo_q;
endmodule
